// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V opcode and PC-increment constants
package rv_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - combinational next-PC select (optional IF_TARGET_ALIGN_EN)
module if_next_pc
    import rv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic [6:0]   opcode,
    input  logic         and_out,
    input  logic [N-1:0] pc_signed_offset,
    output logic [N-1:0] pc_new
);

`ifdef IF_TARGET_ALIGN_EN
    // Redirect targets are forced onto a word boundary.
    localparam logic [N-1:0] TARGET_MASK = {{(N-2){1'b1}}, 2'b00};
`else
    // Redirect targets pass through untouched.
    localparam logic [N-1:0] TARGET_MASK = {N{1'b1}};
`endif

    logic [N-1:0] pc_seq;
    logic [N-1:0] pc_rel;
    logic [N-1:0] pc_ind;

    // Adds wrap modulo 2^N; negative offsets work via two's complement.
    assign pc_seq = pc + N'(PC_INCR);
    assign pc_rel = pc + pc_signed_offset;
    // JALR target is already rs1+imm; the ISA requires bit 0 cleared.
    assign pc_ind = {pc_signed_offset[N-1:1], 1'b0};

    // Priority select: JAL, JALR, taken branch, otherwise sequential.
    always_comb begin
        pc_new = pc_seq;
        if (opcode == OPC_JAL) begin
            pc_new = pc_rel & TARGET_MASK;
        end else if (opcode == OPC_JALR) begin
            pc_new = pc_ind & TARGET_MASK;
        end else if ((opcode == OPC_BRANCH) && and_out) begin
            pc_new = pc_rel & TARGET_MASK;
        end
    end

endmodule

// File: rtl/rv_if_stage.sv
// rtl/rv_if_stage.sv - instruction-fetch stage PC register (optional IF_TARGET_ALIGN_EN)
module rv_if_stage
    import rv_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         and_out,
    input  logic [6:0]   opcode,
    input  logic [N-1:0] pc_signed_offset,
    output logic [N-1:0] address,
    output logic [N-1:0] pc_new
);

    logic [N-1:0] pc_q;

    if_next_pc #(
        .N(N)
    ) u_next_pc (
        .pc               (pc_q),
        .opcode           (opcode),
        .and_out          (and_out),
        .pc_signed_offset (pc_signed_offset),
        .pc_new           (pc_new)
    );

    // PC register: synchronous reset overrides the next-PC select.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_new;
        end
    end

    assign address = pc_q;

endmodule

// File: tb/tb_rv_if_stage.sv
// tb/tb_rv_if_stage.sv - scoreboard bench for rv_if_stage (IF_TARGET_ALIGN_EN aware)
module tb_rv_if_stage;

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        and_out;
    logic [6:0]  opcode;
    logic [31:0] pc_signed_offset;
    logic [31:0] address;
    logic [31:0] pc_new;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    rv_if_stage #(
        .N(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .and_out          (and_out),
        .opcode           (opcode),
        .pc_signed_offset (pc_signed_offset),
        .address          (address),
        .pc_new           (pc_new)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive one cycle: inputs set after the falling edge, pc_new checked
    // mid-cycle, address checked 1 ns after the rising edge.
    task automatic step(input string tag, input logic rst, input logic [6:0] opc,
                        input logic ao, input logic [31:0] off,
                        input logic [31:0] exp_new, input logic [31:0] exp_addr);
        @(negedge clk);
        reset            = rst;
        opcode           = opc;
        and_out          = ao;
        pc_signed_offset = off;
        #1;
        if (!rst) begin
            push({tag, "_pc_new"}, exp_new);
            check_pop(pc_new);
        end
        push({tag, "_address"}, exp_addr);
        @(posedge clk);
        #1;
        check_pop(address);
    endtask

    initial begin
        reset            = 1'b1;
        and_out          = 1'b0;
        opcode           = 7'd0;
        pc_signed_offset = 32'd0;

        // Reset state
        @(posedge clk);
        #1;
        push("reset_address", 32'd0);
        check_pop(address);
        push("reset_pc_new", 32'd4);
        check_pop(pc_new);

        // Basic opcodes
        step("load",      1'b0, LOAD,     1'b0, 32'd8,   32'd4,   32'd4);
        step("jal",       1'b0, JAL,      1'b0, 32'd100, 32'd104, 32'd104);
        step("jalr",      1'b0, JALR,     1'b1, 32'd120, 32'd120, 32'd120);
        step("br_taken",  1'b0, BRANCH,   1'b1, 32'd16,  32'd136, 32'd136);
        step("br_not",    1'b0, BRANCH,   1'b0, 32'd16,  32'd140, 32'd140);
        step("br_neg",    1'b0, BRANCH,   1'b1, -32'sd8, 32'd132, 32'd132);
        step("unknown",   1'b0, 7'h7F,    1'b1, 32'd200, 32'd136, 32'd136);

        // Mid-sequence reset overrides a jump
        step("rst_mid",   1'b1, JAL,      1'b0, 32'd100, 32'd0,   32'd0);

        // Reset glitch between edges must be ignored
        @(negedge clk);
        reset            = 1'b0;
        opcode           = LOAD;
        pc_signed_offset = 32'd4;
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        push("glitch_address", 32'd4);
        @(posedge clk);
        #1;
        check_pop(address);

        // Wrap-around
        step("to_top",    1'b0, JALR,     1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("wrap_seq",  1'b0, LOAD,     1'b0, 32'd0,   32'd0,   32'd0);
        step("wrap_neg",  1'b0, BRANCH,   1'b1, -32'sd4, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

        // Target alignment
        step("rst_align", 1'b1, 7'd0,     1'b0, 32'd0,   32'd0,   32'd0);
`ifdef IF_TARGET_ALIGN_EN
        step("jal_odd",   1'b0, JAL,      1'b0, 32'd6,     32'd4,     32'd4);
        step("jalr_odd",  1'b0, JALR,     1'b0, 32'h103,   32'h100,   32'h100);
        step("seq_keep",  1'b0, LOAD,     1'b0, 32'd0,     32'h104,   32'h104);
`else
        step("jal_odd",   1'b0, JAL,      1'b0, 32'd6,     32'd6,     32'd6);
        step("jalr_odd",  1'b0, JALR,     1'b0, 32'h103,   32'h102,   32'h102);
        step("seq_keep",  1'b0, LOAD,     1'b0, 32'd0,     32'h106,   32'h106);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_if_stage.md
# rv_if_stage

Instruction-fetch stage of the single-cycle RISC-V core. Holds the program counter and drives it to instruction memory as `address`. Combinationally selects the next PC from sequential (PC+4), PC-relative (JAL, taken branch) or register-indirect (JALR) targets, and loads it on every clock edge.

## Interface
- `N`, default 32: address/PC width in bits; must be ≥ 8.
- `RESET_PC`, default 0: PC value loaded on reset (N bits).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `and_out`  in  1: branch-taken flag (branch-control AND of Branch and ALU condition).
- `opcode`  in  7: opcode field of the current instruction.
- `pc_signed_offset`  in  N: two's-complement immediate offset for JAL/branch; absolute target (rs1+imm) for JALR.
- `address`  out  N: current PC, to instruction memory.
- `pc_new`  out  N: next-PC value, loaded into the PC at the next edge.

## Operation
- One PC register, N bits. `address` = PC, driven directly from the register with no combinational path.
- Opcode constants: JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011.
- Next-PC select, purely combinational, with priority in this order:
  - `opcode` == JAL → PC + `pc_signed_offset`.
  - `opcode` == JALR → `pc_signed_offset` with bit 0 cleared.
  - `opcode` == BRANCH and `and_out` = 1 → PC + `pc_signed_offset`.
  - Otherwise, including BRANCH with `and_out` = 0 and all unrecognised opcodes → PC + 4.
- `and_out` is ignored for every opcode other than BRANCH.
- Arithmetic is modulo 2^N. Adds wrap silently with no overflow flag. Negative offsets work through two's-complement addition.
- Example of wrap: PC = 2^N − 4 with a non-branch opcode gives `pc_new` = 0.

## Timing
- Rising edge with `reset` = 1: PC ← `RESET_PC`. Reset overrides the next-PC select.
- Rising edge with `reset` = 0: PC ← `pc_new`.
- Reset values: `address` = `RESET_PC`; `pc_new` = `RESET_PC` + 4 when `opcode` is not a jump or branch.
- `pc_new` follows input changes in the same cycle, with zero-cycle latency.
- A redirect takes effect at the next edge. A jump or taken branch costs no bubble cycles.
- Reset pulses shorter than a clock period that do not cover a rising edge have no effect.
- A reset asserted at any edge, including mid-sequence, restores `RESET_PC` at that edge.
- Inputs may change anywhere between edges; only their values at the edge matter.

## Configuration
- `IF_TARGET_ALIGN_EN` defined:
  - The redirect target of JAL, JALR and taken branch has bits [1:0] forced to 0, keeping the PC word-aligned.
  - PC+4 is unaffected.
- `IF_TARGET_ALIGN_EN` undefined:
  - Targets pass through unmodified, except that JALR still clears bit 0.

## Structure
- Shared package `rv_pkg` holds the opcode constants `OPC_JAL`, `OPC_JALR` and `OPC_BRANCH`, and the PC increment constant (4).
- Sub-module `if_next_pc`:
  - Combinational next-PC mux and adders.
  - Inputs: PC, opcode, `and_out`, offset.
  - Output: `pc_new`.
- The top level holds the PC register and reset logic only.

## Test plan
Run all scenarios with `RESET_PC` = 0 and no macro.

- Reset held across an edge with opcode 0 → `address` = 0, `pc_new` = 4.
- Release reset, then run these opcodes for one edge each:
  - Load (7'b0000011), offset 8 → `address` 4.
  - JAL, offset 100 → `address` 104.
  - JALR, offset 120 → `address` 120.
- Continuing from PC = 120:
  - Branch with `and_out` = 1, offset 16 → `address` 136.
  - Branch with `and_out` = 0, offset 16 → `address` 140.
  - Branch with `and_out` = 1, offset −8 → `address` 132.
  - Opcode 7'b1111111, offset 200 → `address` 136 (PC+4).
- Glitchy reset: toggle `reset` 1/0/1/0 in 5 ns steps around edges → PC = 0 after the edge sampled high. Then load, offset 4 → `address` 4 after the next edge.
- Wrap: PC = 0xFFFFFFFC, non-branch opcode → `pc_new` = 0. Branch taken at PC = 0 with offset −4 → `pc_new` = 0xFFFFFFFC.
- With `IF_TARGET_ALIGN_EN`: JAL from PC 0 with offset 6 → `pc_new` = 4. JALR with offset 0x103 → `pc_new` = 0x100.
